// File: rtl/usb_tx.sv
// USB low/full-speed packet transmitter: SYNC, PID, optional data + CRC16, EOP.
// Latency: SYNC starts the cycle after a request is sampled in IDLE; every bit is CLKS_PER_BIT cycles.
// Backpressure: none on the bus side; requests arriving outside IDLE are dropped; data bytes are pulled with a one-cycle pop.
// Ports: clk/rst (async active-high), tx_packet request code, buffer_occupancy + tx_packet_data +
//   get_tx_packet_data (fall-through buffer), dplus_out/dminus_out bus lines, tx_transfer_active, tx_error.
module usb_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SYNC = 3'd1;
  localparam logic [2:0] PID  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CRC  = 3'd4;
  localparam logic [2:0] EOP  = 3'd5;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [6:0]    byte_left;
  logic [7:0]    shreg;
  logic [7:0]    pid_byte;
  logic          is_data;
  logic [15:0]   crc;
  logic [2:0]    ones;
  logic          stuff;     // current bit time is an inserted stuff bit
  logic          nrzi;      // line level of the previous bit (1 = J)

  logic [7:0]    pid_sel;
  logic          req_ok;
  logic          req_bad;
  logic          bit_end;
  logic          in_stream;
  logic [7:0]    cur_byte;
  logic          data_bit;
  logic          tx_bit;
  logic          lvl;
  logic          six;
  logic          adv;
  logic [15:0]   crc_next;

  always_comb begin
    pid_sel = 8'h00;
    case (tx_packet)
      4'd1:    pid_sel = 8'hC3;
      4'd2:    pid_sel = 8'h4B;
      4'd3:    pid_sel = 8'hD2;
      4'd4:    pid_sel = 8'h5A;
      4'd5:    pid_sel = 8'h1E;
      default: pid_sel = 8'h00;
    endcase
    req_bad = (tx_packet > 4'd5) ||
              (((tx_packet == 4'd1) || (tx_packet == 4'd2)) && (buffer_occupancy > 7'd64));
    req_ok  = (tx_packet != 4'd0) && !req_bad;
  end

  assign bit_end   = (clk_cnt == CNT_MAX);
  assign in_stream = (state == SYNC) || (state == PID) || (state == DATA) || (state == CRC);

  // The buffer is fall-through, so the first bit of a byte is taken straight off
  // tx_packet_data during the pop cycle; the registered copy covers the rest.
  assign get_tx_packet_data = (state == DATA) && (clk_cnt == '0) && (bit_idx == 4'd0) && !stuff;
  assign cur_byte = get_tx_packet_data ? tx_packet_data : shreg;
  assign data_bit = (state == CRC) ? ~crc[0] : cur_byte[0];
  assign tx_bit   = stuff ? 1'b0 : data_bit;
  assign lvl      = tx_bit ? nrzi : ~nrzi;

  // Sixth consecutive raw 1 ends here: a stuff bit follows and the stream position is held.
  assign six = !stuff && data_bit && (ones == 3'd5);
  assign adv = in_stream && bit_end && (stuff || !six);

  // Reflected form of x^16+x^15+x^2+1, data bits fed in transmit order.
  assign crc_next = (crc[0] ^ data_bit) ? ({1'b0, crc[15:1]} ^ 16'hA001) : {1'b0, crc[15:1]};

  always_comb begin
    dplus_out  = 1'b1;
    dminus_out = 1'b0;
    if (in_stream) begin
      dplus_out  = lvl;
      dminus_out = ~lvl;
    end else if ((state == EOP) && (bit_idx != 4'd2)) begin
      dplus_out  = 1'b0;
      dminus_out = 1'b0;
    end
  end

  assign tx_transfer_active = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= 4'd0;
      byte_left <= 7'd0;
      shreg     <= 8'h00;
      pid_byte  <= 8'h00;
      is_data   <= 1'b0;
      crc       <= 16'hFFFF;
      ones      <= 3'd0;
      stuff     <= 1'b0;
      nrzi      <= 1'b1;
      tx_error  <= 1'b0;
    end else begin
      tx_error <= 1'b0;
      if (get_tx_packet_data) shreg <= tx_packet_data;

      case (state)
        IDLE: begin
          nrzi    <= 1'b1;
          clk_cnt <= '0;
          bit_idx <= 4'd0;
          ones    <= 3'd0;
          stuff   <= 1'b0;
          if (req_bad) begin
            tx_error <= 1'b1;
          end else if (req_ok) begin
            state    <= SYNC;
            shreg    <= 8'h80;
            pid_byte <= pid_sel;
            is_data  <= (tx_packet == 4'd1) || (tx_packet == 4'd2);
            crc      <= 16'hFFFF;
          end
        end
        EOP: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            if (bit_idx == 4'd2) begin
              state   <= IDLE;
              bit_idx <= 4'd0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        SYNC, PID, DATA, CRC: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            nrzi <= lvl;
            if (stuff) begin
              stuff <= 1'b0;
              ones  <= 3'd0;
            end else begin
              ones <= data_bit ? ones + 3'd1 : 3'd0;
              if (state == DATA) crc <= crc_next;
              if (six) begin
                stuff <= 1'b1;
                ones  <= 3'd0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Move to the next stream position; skipped during a stuff bit's predecessor.
      if (adv) begin
        case (state)
          SYNC: begin
            if (bit_idx == 4'd7) begin
              state   <= PID;
              shreg   <= pid_byte;
              bit_idx <= 4'd0;
            end else begin
              shreg   <= cur_byte >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
          PID: begin
            if (bit_idx == 4'd7) begin
              bit_idx <= 4'd0;
              if (!is_data) begin
                state <= EOP;
              end else if (buffer_occupancy == 7'd0) begin
                state <= CRC;
              end else begin
                state     <= DATA;
                byte_left <= (buffer_occupancy > 7'd64) ? 7'd64 : buffer_occupancy;
              end
            end else begin
              shreg   <= cur_byte >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
          DATA: begin
            if (bit_idx == 4'd7) begin
              bit_idx   <= 4'd0;
              byte_left <= byte_left - 7'd1;
              if (byte_left == 7'd1) state <= CRC;
            end else begin
              shreg   <= cur_byte >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
          CRC: begin
            crc <= {1'b1, crc[15:1]};
            if (bit_idx == 4'd15) begin
              state   <= EOP;
              bit_idx <= 4'd0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: a packet-level model builds the expected line symbols
// per bit and the expected pop cycles; a negedge monitor compares what the DUT drives.
module tb_usb_tx;

  localparam int CLKS = 8;
  localparam int SE0 = 0, SJ = 1, SK = 2;

  typedef struct {
    int start;
    int nbits;
    int npops;
    bit abort;
  } hdr_t;

  logic       clk;
  logic       rst;
  logic [3:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_transfer_active;
  logic       tx_error;

  logic [7:0] pkt_bytes [0:63];
  int load_cnt;
  int pops;
  int pops_base;
  int cyc;

  hdr_t exp_hdr[$];
  int   exp_sym[$];
  int   exp_get[$];
  int   exp_err[$];

  int n_checks;
  int n_fail;

  usb_tx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk                (clk),
    .rst                (rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fall-through buffer model: head byte always visible, popped on the strobe edge.
  assign buffer_occupancy = 7'(load_cnt - (pops - pops_base));
  assign tx_packet_data   = pkt_bytes[6'(pops - pops_base)];

  initial begin
    pops = 0;
    cyc  = 0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (get_tx_packet_data) pops <= pops + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sym_now();
    case ({dplus_out, dminus_out})
      2'b10:   return SJ;
      2'b01:   return SK;
      2'b00:   return SE0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] pid_of(input int code);
    case (code)
      1:       return 8'hC3;
      2:       return 8'h4B;
      3:       return 8'hD2;
      4:       return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  // Packet model: raw bit list -> bit stuffing -> NRZI -> EOP, all on plain queues.
  task automatic push_expect(input int code, input int n, input bit abort, input int start);
    bit raw[$];
    bit st[$];
    int bstart[$];
    logic [7:0] pid;
    logic [15:0] c;
    int ones;
    int bi;
    int lvl;
    int npops;
    hdr_t h;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    pid = pid_of(code);
    for (int i = 0; i < 8; i++) raw.push_back(pid[i]);
    if (code <= 2) begin
      c = 16'hFFFF;
      for (int b = 0; b < n; b++) begin
        bstart.push_back(raw.size());
        for (int i = 0; i < 8; i++) begin
          bit d;
          bit fb;
          d  = pkt_bytes[b][i];
          raw.push_back(d);
          fb = d ^ c[15];
          c  = {c[14:0], 1'b0};
          if (fb) c = c ^ 16'h8005;
        end
      end
      for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
    end
    ones  = 0;
    bi    = 0;
    npops = 0;
    for (int i = 0; i < raw.size(); i++) begin
      if (bi < bstart.size() && bstart[bi] == i) begin
        exp_get.push_back(st.size() * CLKS);
        npops++;
        bi++;
      end
      st.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        st.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1;
    for (int i = 0; i < st.size(); i++) begin
      if (!st[i]) lvl = 1 - lvl;
      exp_sym.push_back(lvl ? SJ : SK);
    end
    exp_sym.push_back(SE0);
    exp_sym.push_back(SE0);
    exp_sym.push_back(SJ);
    h.start = start;
    h.nbits = st.size() + 3;
    h.npops = npops;
    h.abort = abort;
    exp_hdr.push_back(h);
  endtask

  // Monitor / scoreboard
  bit   in_pkt;
  int   pc;
  hdr_t cur;
  int   syms[$];
  int   gets[$];
  int   obs_get[$];
  int   bad, bad_at, bad_got, bad_exp;

  always @(negedge clk) begin
    if (tx_error) begin
      check("err_expected", exp_err.size() > 0, 1);
      if (exp_err.size() > 0) check("err_cycle", cyc, exp_err.pop_front());
      check("err_active", tx_transfer_active, 0);
      check("err_lines_j", sym_now(), SJ);
    end
    if (get_tx_packet_data) check("pop_while_active", tx_transfer_active, 1);

    if (tx_transfer_active && !in_pkt) begin
      in_pkt = 1'b1;
      pc  = 0;
      bad = 0;
      syms.delete();
      gets.delete();
      obs_get.delete();
      check("pkt_expected", exp_hdr.size() > 0, 1);
      if (exp_hdr.size() > 0) begin
        cur = exp_hdr.pop_front();
        for (int i = 0; i < cur.nbits; i++) syms.push_back(exp_sym.pop_front());
        for (int i = 0; i < cur.npops; i++) gets.push_back(exp_get.pop_front());
        check("start_cycle", cyc, cur.start);
      end else begin
        cur.start = 0; cur.nbits = 0; cur.npops = 0; cur.abort = 1'b0;
      end
    end

    if (tx_transfer_active) begin
      if (get_tx_packet_data) obs_get.push_back(pc);
      if ((pc / CLKS) < syms.size() && sym_now() != syms[pc / CLKS]) begin
        if (bad == 0) begin
          bad_at  = pc;
          bad_got = sym_now();
          bad_exp = syms[pc / CLKS];
        end
        bad++;
      end
      pc++;
    end else if (in_pkt) begin
      in_pkt = 1'b0;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL wave: %0d cycles wrong, first at cycle %0d got sym %0d expected %0d (start %0d)",
                 bad, bad_at, bad_got, bad_exp, cur.start);
      end
      if (!cur.abort) begin
        check("active_len", pc, cur.nbits * CLKS);
        check("pop_count", obs_get.size(), gets.size());
      end else begin
        check("abort_short", pc < cur.nbits * CLKS, 1);
        check("abort_pops_prefix", obs_get.size() <= gets.size(), 1);
      end
      for (int i = 0; i < obs_get.size() && i < gets.size(); i++)
        check("pop_cycle", obs_get[i], gets[i]);
      check("after_pkt_lines_j", sym_now(), SJ);
    end
  end

  // Stimulus
  task automatic send(input int code, input int n, input bit abort);
    load_cnt  = n;
    pops_base = pops;
    if (code >= 1 && code <= 5 && !(code <= 2 && n > 64)) push_expect(code, n, abort, cyc + 1);
    else if (code != 0) exp_err.push_back(cyc + 1);
    tx_packet = 4'(code);
    @(posedge clk);
    #1 tx_packet = 4'd0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 8000; k++) begin
      @(negedge clk);
      if (!tx_transfer_active) break;
    end
    check("done_in_budget", k < 8000, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int code;
    int n;
    int k;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    tx_packet = 4'd0;
    load_cnt  = 0;
    pops_base = 0;
    for (int i = 0; i < 64; i++) pkt_bytes[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_dplus", dplus_out, 1);
    check("rst_dminus", dminus_out, 0);
    check("rst_active", tx_transfer_active, 0);
    check("rst_error", tx_error, 0);
    check("rst_get", get_tx_packet_data, 0);

    // ACK on the first edge after reset release
    rst = 1'b0;
    send(3, 0, 1'b0);
    wait_done();

    // DATA0, empty payload
    @(negedge clk) send(1, 0, 1'b0);
    wait_done();

    // DATA1, one 0xFF byte (stuffing inside the data)
    pkt_bytes[0] = 8'hFF;
    @(negedge clk) send(2, 1, 1'b0);
    wait_done();

    // Rejected requests
    @(negedge clk) send(7, 0, 1'b0);
    @(negedge clk) send(1, 65, 1'b0);
    @(negedge clk) send(2, 65, 1'b0);
    @(negedge clk) send(15, 0, 1'b0);
    repeat (4) @(negedge clk);

    // Random packets; one gets a NAK request thrown at it mid-flight
    for (int it = 0; it < 10; it++) begin
      code = $urandom_range(1, 5);
      n    = $urandom_range(0, 12);
      k    = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) pkt_bytes[i] = (k == 0) ? 8'hFF : 8'($urandom);
      @(negedge clk) send(code, n, 1'b0);
      if (it == 3) begin
        repeat (40) @(negedge clk);
        tx_packet = 4'd4;
        repeat (3) @(negedge clk);
        tx_packet = 4'd0;
      end
      wait_done();
    end

    // Largest payload, all ones
    for (int i = 0; i < 64; i++) pkt_bytes[i] = 8'hFF;
    @(negedge clk) send(1, 64, 1'b0);
    wait_done();

    // Reset during the third byte of a 10-byte packet
    for (int i = 0; i < 64; i++) pkt_bytes[i] = 8'($urandom);
    @(negedge clk) send(1, 10, 1'b1);
    for (k = 0; k < 3000 && (pops - pops_base) < 3; k++) @(negedge clk);
    check("abort_reached_byte3", (pops - pops_base) >= 3, 1);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_rst_lines_j", sym_now(), SJ);
    check("abort_rst_active", tx_transfer_active, 0);
    check("abort_rst_get", get_tx_packet_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(3, 0, 1'b0);
    wait_done();

    repeat (5) @(negedge clk);
    check("pkt_queue_empty", exp_hdr.size(), 0);
    check("err_queue_empty", exp_err.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
